serial_bit_deserializer: RTL
============================

# serial_bit_deserializer

Collects a 1-bit serial stream, one accepted bit per clock, into WIDTH-bit words, with optional per-bit inversion through the mux-built not path. It sits directly downstream of the mux/not-gate bit stage, which drives `in_bit`. It presents each finished word on a single-entry valid/ready output register for the word-level logic that follows.

## Interface

- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `clear`  input  1: synchronous discard of the partial word.
- `in_valid`  input  1: `in_bit` is presented.
- `in_ready`  output  1: block accepts `in_bit` this cycle.
- `in_bit`  input  1: serial data bit, LSB of word first.
- `invert`  input  1: sampled with each accepted bit; 1 stores the complement.
- `out_valid`  output  1: `out_data` holds a complete word.
- `out_ready`  input  1: downstream takes the word this cycle.
- `out_data`  output  WIDTH: assembled word.
- `bit_cnt`  output  $clog2(WIDTH): bits held in the partial word.

## Operation

- Bit acceptance occurs on a rising edge with `in_valid && in_ready`.
- Stored bit = `invert ? ~in_bit : in_bit`. Build it with a 2:1 mux and constants, not XOR: the mux selects on `invert`, with `d0 = in_bit` and `d1 =` the not-of-`in_bit` mux output.
- Accepted bit k (0-based within the word) is written to position k of the shift/assembly register. Position 0 is the LSB.
- `bit_cnt` counts 0..WIDTH-1 and increments per accepted bit.
  - When it accepts bit WIDTH-1, `bit_cnt` wraps to 0.
  - On that same edge, the assembled word, including the final bit, loads into `out_data` and `out_valid` sets to 1.
- Output register:
  - `out_valid` clears on an edge with `out_ready` high, unless the same edge loads a new word.
  - If the same edge loads a new word, `out_valid` stays 1 and `out_data` takes the new word.
  - `out_data` holds its value while `out_valid=0`, and holds while `out_valid && !out_ready`.
- `in_ready = !clear && (bit_cnt != WIDTH-1 || !out_valid || out_ready)`. This is combinational on `out_ready` and `clear`.
  - Partial-word bits continue to flow while the output is stalled.
  - Only the completing bit waits.
- `clear`:
  - `bit_cnt` goes to 0 and the partial word is discarded. Assembly register contents become don't-care, but are zeroed.
  - `out_valid`/`out_data` are unaffected, and an `out_ready` handshake still completes that cycle.
  - A bit presented while `clear=1` is not accepted (`in_ready=0`).
- Reset: `bit_cnt=0`, assembly register=0, `out_valid=0`, `out_data=0`. Hence `in_ready=1` with `clear=0`.
- Reset asserted mid-word or with a pending output discards everything immediately, asynchronously.
- `in_valid=0` cycles are bubbles: no state change on the input side.

## Timing

- Throughput: 1 bit/clock; one word per WIDTH accepted bits. Sustained with `out_ready=1` there is no lost cycle at word boundaries.
- Latency: `out_valid` rises on the same edge that accepts bit WIDTH-1. It is visible in the cycle after that edge.
- Backpressure bound: with `out_valid=1, out_ready=0`, at most WIDTH-1 further bits are accepted. Then `in_ready` drops until `out_ready=1`.
- Simultaneous completing bit and `out_ready=1` with `out_valid=1`:
  - The old word is consumed and the new word loaded on the same edge.
  - `out_valid` stays 1 and no word is lost.
- Release of `rst_n` is synchronous to `clk` externally. The first acceptance is possible on the first edge after release.

## Test plan

- Reset check: hold `rst_n=0` with random inputs. Required: `out_valid=0`, `out_data=0`, `bit_cnt=0`. After release, `in_ready=1`.
- Basic word (WIDTH=8): `invert=0`, bits of 0xA5 LSB first on 8 consecutive cycles, `out_ready=1`. Required: `out_valid=1` with `out_data=0xA5` in the cycle after the 8th edge, for exactly one cycle.
- Inversion: same stream with `invert=1` on all bits gives `out_data=0x5A`. With `invert=1` only on bits 0 and 7, the result is `0x24`.
- Backpressure: `out_ready=0`, send 0x0F then 0xF0 back-to-back.
  - Required: the 0x0F word holds, and `in_ready=0` when `bit_cnt=7`.
  - Raise `out_ready`: 0x0F is consumed, the 8th bit is accepted the same edge, then `out_data=0xF0`, `out_valid` stays 1.
- Clear mid-word: accept 3 bits, pulse `clear` with `in_valid=1`.
  - Required: `in_ready=0` that cycle and `bit_cnt=0` after.
  - The next 8 bits of 0x3C give `out_data=0x3C`.
- Async reset mid-word: after 5 bits and with a pending word, drop `rst_n` between edges. Required: `out_valid` and `bit_cnt` go to 0 without waiting for `clk`, and the next full word assembles correctly.

Source files
------------

// File: rtl/serial_bit_deserializer.sv
// serial_bit_deserializer
//   Gathers a 1-bit serial stream (LSB first, one accepted bit per clock) into
//   WIDTH-bit words. Each bit may be inverted on the way in. Completed words
//   are held in a single-entry valid/ready output register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous discard of the partial word (output word untouched)
//   in_valid   in_bit is presented
//   in_ready   bit accepted this cycle (combinational on clear/out_ready)
//   in_bit     serial data bit
//   invert     1 stores the complement of in_bit
//   out_valid  out_data holds a complete word
//   out_ready  downstream takes the word this cycle
//   out_data   assembled word
//   bit_cnt    number of bits held in the partial word
module serial_bit_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bit,
  input  logic                     invert,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // 2:1 multiplexer primitive; the bit stage is built only from these.
  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    logic y;
    if (sel) begin
      y = d1;
    end else begin
      y = d0;
    end
    return y;
  endfunction

  logic             not_bit_s;
  logic             stored_bit_s;
  logic             last_s;
  logic             accept_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] asm_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;

  logic [WIDTH-1:0] asm_r;
  logic [CW-1:0]    bit_cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  // Bit stage: NOT made from a mux on constants, then the invert select mux.
  always_comb begin
    not_bit_s    = mux2(in_bit, 1'b1, 1'b0);
    stored_bit_s = mux2(invert, in_bit, not_bit_s);
  end

  // Input handshake: only the word-completing bit waits for output space.
  always_comb begin
    last_s     = (bit_cnt_r == LAST_IDX);
    in_ready_s = !clear && (!last_s || !out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Complete word as it would be with the current bit in the top position.
  always_comb begin
    word_s           = asm_r;
    word_s[WIDTH-1]  = stored_bit_s;
  end

  // Next-state for the assembly register, bit counter and output register.
  always_comb begin
    asm_nxt_s   = asm_r;
    cnt_nxt_s   = bit_cnt_r;
    valid_nxt_s = out_valid_r;
    data_nxt_s  = out_data_r;

    if (clear) begin
      asm_nxt_s = '0;
      cnt_nxt_s = '0;
    end else if (accept_s) begin
      if (last_s) begin
        asm_nxt_s = '0;
        cnt_nxt_s = '0;
      end else begin
        asm_nxt_s[bit_cnt_r] = stored_bit_s;
        cnt_nxt_s            = bit_cnt_r + CNT_ONE;
      end
    end else begin
      asm_nxt_s = asm_r;
    end

    // A new word wins over consumption, so a same-edge load keeps valid high.
    if (accept_s && last_s) begin
      valid_nxt_s = 1'b1;
      data_nxt_s  = word_s;
    end else if (out_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = out_valid_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r       <= '0;
      bit_cnt_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      asm_r       <= asm_nxt_s;
      bit_cnt_r   <= cnt_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_data_r  <= data_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign bit_cnt   = bit_cnt_r;

endmodule
